axi4_lite_slave: RTL and testbench
==================================

AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the width of AWADDR and ARADDR.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the width of WDATA and RDATA.
REQ-003 The block SHALL have parameter MEM_WORDS, default 16, the register-file depth in words (power of two, minimum 2).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port ACLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port ARESET, input, 1, the reset; reset is asynchronous and active-high.
REQ-006 The block SHALL have port AWADDR, input, ADDR_WIDTH, the write address.
REQ-007 The block SHALL have port AWVALID, input, 1, the write address valid.
REQ-008 The block SHALL have port AWREADY, output, 1, the write address ready.
REQ-009 The block SHALL have port WDATA, input, DATA_WIDTH, the write data.
REQ-010 The block SHALL have port WVALID, input, 1, the write data valid.
REQ-011 The block SHALL have port WREADY, output, 1, the write data ready.
REQ-012 The block SHALL have port BRESP, output, 2, the write response.
REQ-013 The block SHALL have port BVALID, output, 1, the write response valid.
REQ-014 The block SHALL have port BREADY, input, 1, the write response ready.
REQ-015 The block SHALL have port ARADDR, input, ADDR_WIDTH, the read address.
REQ-016 The block SHALL have port ARVALID, input, 1, the read address valid.
REQ-017 The block SHALL have port ARREADY, output, 1, the read address ready.
REQ-018 The block SHALL have port RDATA, output, DATA_WIDTH, the read data.
REQ-019 The block SHALL have port RRESP, output, 2, the read response.
REQ-020 The block SHALL have port RVALID, output, 1, the read data valid.
REQ-021 The block SHALL have port RREADY, input, 1, the read data ready.

Function
REQ-022 Storage SHALL be MEM_WORDS x DATA_WIDTH registers, word index = addr[log2(MEM_WORDS)+1:2], with addr[1:0] ignored.
REQ-023 The write FSM SHALL have states WR_IDLE, WR_WAIT and WR_RESP; the read FSM SHALL have states RD_IDLE and RD_DATA, independent of the write FSM.
REQ-024 AWREADY SHALL be 1 in WR_IDLE/WR_WAIT while no address is captured; WREADY SHALL be 1 in WR_IDLE/WR_WAIT while no data is captured; both SHALL be 0 in WR_RESP.
REQ-025 The AW and W handshakes SHALL be accepted in either order or in the same cycle; when only one is done the FSM SHALL go WR_IDLE->WR_WAIT and hold the captured item.
REQ-026 On the edge completing both captures, the word SHALL be written and the FSM SHALL enter WR_RESP with BVALID=1 and BRESP=2'b00 (OKAY) the next cycle.
REQ-027 BVALID and BRESP SHALL hold stable until BVALID&&BREADY, after which the FSM SHALL return to WR_IDLE with BVALID=0.
REQ-028 ARREADY SHALL be 1 only in RD_IDLE; on ARVALID&&ARREADY, RDATA SHALL register the addressed word, RRESP=2'b00, RVALID=1 the next cycle (latency 1), and the FSM SHALL enter RD_DATA.
REQ-029 RDATA, RRESP and RVALID SHALL hold stable in RD_DATA until RVALID&&RREADY, then the FSM SHALL return to RD_IDLE with RVALID=0.
REQ-030 A read capture and a write commit to the same word on the same edge SHALL return the old data; a later read SHALL return the new data.
REQ-031 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-032 On ARESET=1, both FSMs SHALL go to idle asynchronously, with AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, and all storage words 0.
REQ-033 The ready outputs SHALL rise on the first ACLK edge after ARESET falls.
REQ-034 Reset asserted mid-transaction SHALL discard any captured address/data and any pending response, and no memory write SHALL occur.

Configuration
REQ-035 With AXI4_LITE_SLAVE_ADDR_CHECK_EN defined, any address with bits above log2(MEM_WORDS)+1 nonzero SHALL get SLVERR (2'b10) on BRESP/RRESP, the write SHALL be discarded, and RDATA SHALL be 0; handshake timing SHALL be unchanged.
REQ-036 Without AXI4_LITE_SLAVE_ADDR_CHECK_EN, the upper address bits SHALL be ignored (address aliasing) and responses SHALL always be OKAY.

Verification
REQ-037 The bench SHALL cover: AW and W same cycle, addr 0x8, data 0xDEADBEEF, BREADY=1 -> BVALID one cycle after the handshake, BRESP=0; a read of 0x8 then returns 0xDEADBEEF one cycle after AR.
REQ-038 The bench SHALL cover: W three cycles before AW, addr 0x4, data 0x1234 -> WREADY=0 after the W capture, AWREADY stays 1, a single write occurs, and a read of 0x4 returns 0x1234.
REQ-039 The bench SHALL cover: BREADY held low for 5 cycles -> BVALID=1 and BRESP stable throughout, AWREADY=WREADY=0, and no second write is accepted.
REQ-040 The bench SHALL cover: a read of 0xC issued on the same edge as a write commit of 0x55 to 0xC -> RDATA is old value 0; the next read returns 0x55.
REQ-041 The bench SHALL cover: ARESET pulsed while in WR_WAIT with data captured -> BVALID never rises and all words read back 0.
REQ-042 The bench SHALL cover: with AXI4_LITE_SLAVE_ADDR_CHECK_EN defined, a write of 0xAA to addr 0x100 -> BRESP=2'b10 and a read of 0x0 returns 0; without the macro, the same write gives BRESP=0 and a read of 0x0 returns 0xAA.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave
//   AXI4-Lite slave backed by a MEM_WORDS x DATA_WIDTH register file.
//   Independent write (WR_IDLE/WR_WAIT/WR_RESP) and read (RD_IDLE/RD_DATA)
//   state machines. Every output is a flop; there is no input->output
//   combinational path.
//
// Ports
//   ACLK, ARESET                        clock, async active-high reset
//   AWADDR/AWVALID/AWREADY              write address channel
//   WDATA/WVALID/WREADY                 write data channel
//   BRESP/BVALID/BREADY                 write response channel
//   ARADDR/ARVALID/ARREADY              read address channel
//   RDATA/RRESP/RVALID/RREADY           read data channel
//
// Configuration
//   AXI4_LITE_SLAVE_ADDR_CHECK_EN  when defined, addresses with any bit set
//   above the word-index field get SLVERR, writes to them are dropped and
//   reads return 0. When undefined, upper address bits alias.
// -----------------------------------------------------------------------------
module axi4_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_e;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

    wr_state_e             wr_state_q;
    rd_state_e             rd_state_q;
    logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_got_q, w_got_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // Write commit happens on the edge that completes the second capture,
    // so address/data come straight from the bus if they arrive this cycle.
    logic                  aw_hs, w_hs, aw_have, w_have, wr_fire;
    logic                  wr_addr_ok, rd_addr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign aw_hs   = AWVALID && awready_q;
    assign w_hs    = WVALID && wready_q;
    assign aw_have = aw_got_q || aw_hs;
    assign w_have  = w_got_q || w_hs;
    assign wr_fire = (wr_state_q != WR_RESP) && aw_have && w_have;
    assign wr_addr = aw_hs ? AWADDR : waddr_q;
    assign wr_data = w_hs ? WDATA : wdata_q;
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign rd_idx  = ARADDR[IDX_W+1:2];

`ifdef AXI4_LITE_SLAVE_ADDR_CHECK_EN
    assign wr_addr_ok = (wr_addr >> (IDX_W + 2)) == '0;
    assign rd_addr_ok = (ARADDR >> (IDX_W + 2)) == '0;
`else
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 1'b1;
`endif

    // Byte-offset bits (and upper bits when aliasing) carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr, ARADDR};

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    // Register file
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_fire && wr_addr_ok) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Write FSM
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE, WR_WAIT: begin
                    if (aw_hs) waddr_q <= AWADDR;
                    if (w_hs)  wdata_q <= WDATA;
                    if (wr_fire) begin
                        wr_state_q <= WR_RESP;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        aw_got_q   <= 1'b0;
                        w_got_q    <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        // Readies also come up here on the first edge out of reset.
                        wr_state_q <= (aw_have || w_have) ? WR_WAIT : WR_IDLE;
                        aw_got_q   <= aw_have;
                        w_got_q    <= w_have;
                        awready_q  <= !aw_have;
                        wready_q   <= !w_have;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        wr_state_q <= WR_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read FSM; the old word is returned when a write commits on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (ARVALID && arready_q) begin
                        rd_state_q <= RD_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_addr_ok ? mem_q[rd_idx] : '0;
                        rresp_q    <= rd_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
module tb_axi4_lite_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [1:0]  resp;   // expected BRESP / RRESP
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit aw_ok, w_ok;
        int n;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (AWVALID && AWREADY) aw_ok = 1;
            if (WVALID && WREADY)   w_ok = 1;
            @(negedge ACLK); n++;
            if (aw_ok) AWVALID = 1'b0;
            if (w_ok)  WVALID  = 1'b0;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        if (!(aw_ok && w_ok)) check("wr_handshake_timeout", 32'd0, 32'd1);
        n = 0;
        while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
        check("wr_bvalid", {31'd0, BVALID}, 32'd1);
        resp = BRESP;
        @(negedge ACLK);
        check("wr_bvalid_drop", {31'd0, BVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (!ARREADY) check("rd_arready_timeout", 32'd0, 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("rd_latency1_rvalid", {31'd0, RVALID}, 32'd1);
        d = RDATA; resp = RRESP;
        @(negedge ACLK);
    endtask

    vec_t        vecs[8];
    logic [31:0] rd;
    logic [1:0]  rs;
    bit          seen;

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; WDATA = '0; ARADDR = '0;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;

        vecs[0] = '{1'b1, 32'h00, 32'h1111_1111, 2'b00};
        vecs[1] = '{1'b1, 32'h3C, 32'hCAFE_F00D, 2'b00};  // last word
        vecs[2] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 2'b00};
        vecs[3] = '{1'b0, 32'h00, 32'h1111_1111, 2'b00};
        vecs[4] = '{1'b0, 32'h3C, 32'hCAFE_F00D, 2'b00};
        vecs[5] = '{1'b0, 32'h3F, 32'hCAFE_F00D, 2'b00};  // byte offset ignored
        vecs[6] = '{1'b0, 32'h10, 32'hA5A5_A5A5, 2'b00};
        vecs[7] = '{1'b0, 32'h20, 32'h0000_0000, 2'b00};  // never written

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_awready", {31'd0, AWREADY}, 0);
        check("rst_wready",  {31'd0, WREADY},  0);
        check("rst_arready", {31'd0, ARREADY}, 0);
        check("rst_bvalid",  {31'd0, BVALID},  0);
        check("rst_rvalid",  {31'd0, RVALID},  0);
        check("rst_rdata",   RDATA, 0);
        check("rst_resps",   {28'd0, BRESP, RRESP}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_awready", {31'd0, AWREADY}, 1);
        check("post_rst_wready",  {31'd0, WREADY},  1);
        check("post_rst_arready", {31'd0, ARREADY}, 1);

        // Table-driven traffic
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, rs);
                check($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
            end else begin
                do_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
                check($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
            end
        end

        do_reset();

        // AW and W in the same cycle
        @(negedge ACLK);
        AWADDR = 32'h8; WDATA = 32'hDEAD_BEEF; AWVALID = 1; WVALID = 1; BREADY = 1;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        check("same_cyc_bvalid", {31'd0, BVALID}, 1);
        check("same_cyc_bresp",  {30'd0, BRESP}, 0);
        @(negedge ACLK);
        check("same_cyc_bvalid_drop", {31'd0, BVALID}, 0);
        do_read(32'h8, rd, rs);
        check("same_cyc_rdata", rd, 32'hDEAD_BEEF);

        // W three cycles ahead of AW
        @(negedge ACLK);
        WDATA = 32'h1234; WVALID = 1;
        @(negedge ACLK);
        WVALID = 0;
        for (int i = 0; i < 3; i++) begin
            check("w_first_wready",  {31'd0, WREADY},  0);
            check("w_first_awready", {31'd0, AWREADY}, 1);
            check("w_first_bvalid",  {31'd0, BVALID},  0);
            if (i < 2) @(negedge ACLK);
        end
        AWADDR = 32'h4; AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        check("w_first_bvalid_set", {31'd0, BVALID}, 1);
        @(negedge ACLK);
        check("w_first_single_write", {31'd0, BVALID}, 0);
        do_read(32'h4, rd, rs);
        check("w_first_rdata", rd, 32'h1234);

        // BREADY held low: response stalls, new write not accepted
        @(negedge ACLK);
        BREADY = 0; AWADDR = 32'h14; WDATA = 32'h77; AWVALID = 1; WVALID = 1;
        @(negedge ACLK);
        WDATA = 32'h99;  // second write kept on the bus during the stall
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid",  {31'd0, BVALID},  1);
            check("stall_bresp",   {30'd0, BRESP},   0);
            check("stall_awready", {31'd0, AWREADY}, 0);
            check("stall_wready",  {31'd0, WREADY},  0);
            @(negedge ACLK);
        end
        AWVALID = 0; WVALID = 0; BREADY = 1;
        @(negedge ACLK);
        check("stall_release", {31'd0, BVALID}, 0);
        do_read(32'h14, rd, rs);
        check("stall_rdata", rd, 32'h77);

        // Read and write-commit to the same word on one edge
        @(negedge ACLK);
        check("rw_same_rdy", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        AWADDR = 32'hC; WDATA = 32'h55; ARADDR = 32'hC;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        check("rw_same_rvalid", {31'd0, RVALID}, 1);
        check("rw_same_old",    RDATA, 32'h0);
        check("rw_same_bvalid", {31'd0, BVALID}, 1);
        @(negedge ACLK);
        do_read(32'hC, rd, rs);
        check("rw_same_new", rd, 32'h55);

        // Reset while waiting with only data captured
        do_reset();
        @(negedge ACLK);
        WDATA = 32'hBEEF; AWADDR = 32'h18; WVALID = 1;
        @(negedge ACLK);
        WVALID = 0;
        check("wait_wready", {31'd0, WREADY}, 0);
        #2 ARESET = 1;
        #1 check("async_rst_awready", {31'd0, AWREADY}, 0);
        check("async_rst_bvalid", {31'd0, BVALID}, 0);
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        AWVALID = 1;  // would complete the write if data had survived
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            AWVALID = 0;
            if (BVALID) seen = 1;
        end
        check("rst_mid_no_bvalid", {31'd0, seen}, 0);
        for (int w = 0; w < 16; w++) begin
            do_read(w * 4, rd, rs);
            check($sformatf("rst_mid_word%0d", w), rd, 0);
        end
        do_reset();

        // Out-of-range address
        do_write(32'h100, 32'hAA, rs);
`ifdef AXI4_LITE_SLAVE_ADDR_CHECK_EN
        check("oor_bresp", {30'd0, rs}, 32'd2);
        do_read(32'h0, rd, rs);
        check("oor_word0", rd, 32'h0);
        do_read(32'h100, rd, rs);
        check("oor_rresp", {30'd0, rs}, 32'd2);
        check("oor_rdata", rd, 32'h0);
`else
        check("alias_bresp", {30'd0, rs}, 32'd0);
        do_read(32'h0, rd, rs);
        check("alias_word0", rd, 32'hAA);
        check("alias_rresp", {30'd0, rs}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
